// File: rtl/conf_loader_pkg.sv
// Shared state type, header layout and strobe addressing for the configuration frame loader.
package conf_loader_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, SKIP, CHECK} state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hFA;

  localparam int unsigned SYNC_LSB  = 24;
  localparam int unsigned COL_LSB   = 16;
  localparam int unsigned FRAME_LSB = 8;

  function automatic int unsigned strobe_index(input logic [7:0] column,
                                               input logic [7:0] frame,
                                               input int unsigned frames_per_col);
    return 32'(column) * frames_per_col + 32'(frame);
  endfunction

endpackage

// File: rtl/conf_frame_decoder.sv
// Registered one-hot FrameStrobe generator: launches on fire, holds while the width counter runs.
module conf_frame_decoder
  import conf_loader_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumColumns      = 4
) (
  input  logic                                  CLK,
  input  logic                                  resetn,
  input  logic [7:0]                            column,
  input  logic [7:0]                            frame,
  input  logic                                  fire,
  input  logic                                  active,
  input  logic [3:0]                            width,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe
);

  localparam int unsigned NumBits = NumColumns * MaxFramesPerCol;

  logic [NumBits-1:0] strobe_next;
  int unsigned        idx;

  always_comb begin
    strobe_next = '0;
    idx = strobe_index(column, frame, MaxFramesPerCol);
    if (fire || (active && width != '0)) begin
      for (int unsigned i = 0; i < NumBits; i++) begin
        strobe_next[i] = (i == idx);
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FrameStrobe <= '0;
    end else begin
      FrameStrobe <= strobe_next;
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Bitstream word loader: decodes frame headers, assembles FrameData rows, pulses one FrameStrobe bit.
// Optional XOR trailer check enabled by defining CONF_FRAME_CRC_EN.
module config_frame_loader
  import conf_loader_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumRows         = 4,
  parameter int unsigned NumColumns      = 4,
  parameter int unsigned StrobeCycles    = 1
) (
  input  logic                                  CLK,
  input  logic                                  resetn,
  input  logic                                  MODE,
  input  logic [31:0]                           in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  error,
  output logic [15:0]                           frames_done
);

  localparam int unsigned RowW = $clog2(NumRows + 2);
`ifdef CONF_FRAME_CRC_EN
  localparam int unsigned SkipWords = NumRows + 1;
`else
  localparam int unsigned SkipWords = NumRows;
`endif
  localparam logic [RowW-1:0] LastRow    = RowW'(NumRows - 1);
  localparam logic [RowW-1:0] LastSkip   = RowW'(SkipWords - 1);
  localparam logic [RowW-1:0] RowOne     = RowW'(1);
  localparam logic [7:0]      ColLimit   = 8'(NumColumns);
  localparam logic [7:0]      FrameLimit = 8'(MaxFramesPerCol);
  localparam logic [3:0]      WidthLoad  = 4'(StrobeCycles - 1);

  state_t          state, state_next;
  logic            run;
  logic            accept, hdr_sync, hdr_range;
  logic            fire, load_wr, row_step, set_error, latch_hdr, count_done;
  logic [RowW-1:0] row_cnt;
  logic [7:0]      col_q, frame_q;
  logic [3:0]      width_cnt;
`ifdef CONF_FRAME_CRC_EN
  logic [31:0]     crc_acc;
`endif

  // run keeps in_ready low while reset is held, even with MODE already high
  assign in_ready  = run && MODE && (state != STROBE);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign hdr_sync  = (in_data[SYNC_LSB +: 8] == SYNC_BYTE);
  assign hdr_range = (in_data[COL_LSB +: 8] < ColLimit) && (in_data[FRAME_LSB +: 8] < FrameLimit);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fire       = 1'b0;
    load_wr    = 1'b0;
    row_step   = 1'b0;
    set_error  = 1'b0;
    latch_hdr  = 1'b0;
    count_done = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!hdr_sync) begin
            set_error = 1'b1;
          end else begin
            latch_hdr  = 1'b1;
            set_error  = !hdr_range;
            state_next = hdr_range ? LOAD : SKIP;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          load_wr  = 1'b1;
          row_step = 1'b1;
          if (row_cnt == LastRow) begin
`ifdef CONF_FRAME_CRC_EN
            state_next = CHECK;
`else
            state_next = STROBE;
            fire       = 1'b1;
`endif
          end
        end
      end
`ifdef CONF_FRAME_CRC_EN
      CHECK: begin
        if (accept) begin
          if (in_data == crc_acc) begin
            state_next = STROBE;
            fire       = 1'b1;
          end else begin
            set_error  = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      STROBE: begin
        if (width_cnt == '0) begin
          state_next = IDLE;
          count_done = MODE;
        end
      end
      SKIP: begin
        if (accept) begin
          row_step = 1'b1;
          if (row_cnt == LastSkip) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Leaving configuration mode aborts any transfer; the registered strobe drops with it
    if (!MODE && state != IDLE) state_next = IDLE;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      run         <= 1'b0;
      row_cnt     <= '0;
      col_q       <= '0;
      frame_q     <= '0;
      width_cnt   <= '0;
      FrameData   <= '0;
      error       <= 1'b0;
      frames_done <= '0;
    end else begin
      run <= 1'b1;
      if (latch_hdr) begin
        col_q   <= in_data[COL_LSB +: 8];
        frame_q <= in_data[FRAME_LSB +: 8];
        row_cnt <= '0;
      end else if (row_step) begin
        row_cnt <= row_cnt + RowOne;
      end
      // First data word of a frame lands in the top row
      for (int unsigned r = 0; r < NumRows; r++) begin
        if (load_wr && r == NumRows - 1 - 32'(row_cnt)) begin
          FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= in_data;
        end
      end
      if (fire) begin
        width_cnt <= WidthLoad;
      end else if (state == STROBE && width_cnt != '0) begin
        width_cnt <= width_cnt - 4'd1;
      end
      if (set_error)  error       <= 1'b1;
      if (count_done) frames_done <= frames_done + 16'd1;
    end
  end

`ifdef CONF_FRAME_CRC_EN
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      crc_acc <= '0;
    end else if (latch_hdr) begin
      crc_acc <= in_data;
    end else if (load_wr) begin
      crc_acc <= crc_acc ^ in_data;
    end
  end
`endif

  conf_frame_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .NumColumns     (NumColumns)
  ) u_decoder (
    .CLK        (CLK),
    .resetn     (resetn),
    .column     (col_q),
    .frame      (frame_q),
    .fire       (fire),
    .active     ((state == STROBE) && MODE),
    .width      (width_cnt),
    .FrameStrobe(FrameStrobe)
  );

endmodule

// File: tb/tb_config_frame_loader.sv
// Randomized self-checking bench for config_frame_loader against a frame-level reference model.
`timescale 1ns/1ps
module tb_config_frame_loader;

  localparam int S  = 2;
  localparam int NB = 80;

  logic          CLK = 1'b0;
  logic          resetn, MODE, in_valid, in_ready, busy, error;
  logic [31:0]   in_data;
  logic [127:0]  FrameData;
  logic [NB-1:0] FrameStrobe;
  logic [15:0]   frames_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int            ev_cyc[$];
  logic [NB-1:0] ev_vec[$];
  logic [15:0]   ev_fd[$];

  logic [127:0] exp_fd;
  logic [15:0]  exp_done;
  logic         exp_err;

  config_frame_loader #(
    .MaxFramesPerCol(20),
    .FrameBitsPerRow(32),
    .NumRows        (4),
    .NumColumns     (4),
    .StrobeCycles   (S)
  ) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .MODE       (MODE),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .busy       (busy),
    .error      (error),
    .frames_done(frames_done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (FrameStrobe !== '0) begin
      ev_cyc.push_back(cyc);
      ev_vec.push_back(FrameStrobe);
      ev_fd.push_back(frames_done);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Returns strobe bit for a header, -1 for out-of-range address, -2 for bad sync
  function automatic int frame_target(input logic [31:0] hdr);
    int col, frm;
    col = int'((hdr >> 16) & 32'hFF);
    frm = int'((hdr >> 8) & 32'hFF);
    if ((hdr >> 24) != 32'hFA) return -2;
    if (col >= 4 || frm >= 20) return -1;
    return col * 20 + frm;
  endfunction

  function automatic bit strobe_matches(input int acc, input int idx, input logic [15:0] fd_now);
    logic [NB-1:0] e;
    if (idx < 0) return ev_cyc.size() == 0;
    if (ev_cyc.size() != S) return 1'b0;
    e = '0;
    e[idx] = 1'b1;
    for (int i = 0; i < S; i++) begin
      if (ev_cyc[i] != acc + 1 + i || ev_vec[i] !== e || ev_fd[i] !== fd_now) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int first_ev();
    return (ev_cyc.size() > 0) ? ev_cyc[0] : -1;
  endfunction

  task automatic clear_ev();
    ev_cyc.delete();
    ev_vec.delete();
    ev_fd.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, output int acc, output bit ok);
    int g;
    g = (gap > 0) ? $urandom_range(0, gap) : 0;
    in_valid = 1'b0;
    wait_cycles(g);
    in_valid = 1'b1;
    in_data  = w;
    ok  = 1'b0;
    acc = -1;
    for (int t = 0; t < 64; t++) begin
      @(negedge CLK);
      if (in_ready === 1'b1) begin
        acc = cyc;
        ok  = 1'b1;
      end
      @(posedge CLK);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] hdr, w0, w1, w2, w3, input bit bad_crc,
                            input int gap, output int acc, output bit ok);
    bit k;
    logic [31:0] tr;
    send_word(hdr, gap, acc, k); ok = k;
    send_word(w0, gap, acc, k);  ok = ok & k;
    send_word(w1, gap, acc, k);  ok = ok & k;
    send_word(w2, gap, acc, k);  ok = ok & k;
    send_word(w3, gap, acc, k);  ok = ok & k;
`ifdef CONF_FRAME_CRC_EN
    tr = hdr ^ w0 ^ w1 ^ w2 ^ w3;
    if (bad_crc) tr = tr ^ 32'h1;
    send_word(tr, gap, acc, k);  ok = ok & k;
`else
    tr = {31'd0, bad_crc};
`endif
  endtask

  task automatic test_reset();
    resetn = 1'b0; MODE = 1'b1; in_valid = 1'b0; in_data = '0;
    exp_fd = '0; exp_done = '0; exp_err = 1'b0;
    wait_cycles(3);
    checks++;
    if (FrameData !== '0 || FrameStrobe !== '0) begin
      errors++; $display("FAIL reset_data: FrameData=%h FrameStrobe=%h, required 0", FrameData, FrameStrobe);
    end
    checks++;
    if ({in_ready, busy, error} !== 3'b000 || frames_done !== 16'd0) begin
      errors++; $display("FAIL reset_ctrl: ready=%b busy=%b error=%b done=%0d, required 0", in_ready, busy, error, frames_done);
    end
    resetn = 1'b1;
    wait_cycles(2);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_ready: ready=%b busy=%b, required ready=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    int acc; bit ok;
    clear_ev();
    send_frame(32'hFA010300, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 0, acc, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL basic_accept: ok=%b, required 1", ok); end
    for (int j = 1; j <= S + 1; j++) begin
      @(negedge CLK);
      checks++;
      if (in_ready !== (j == S + 1)) begin
        errors++; $display("FAIL basic_ready_cyc%0d: ready=%b, required %b", j, in_ready, (j == S + 1));
      end
    end
    @(posedge CLK); #1;
    wait_cycles(2);
    exp_fd = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    checks++;
    if (!strobe_matches(acc, 23, exp_done)) begin
      errors++; $display("FAIL basic_strobe: %0d events from cyc %0d, required %0d on bit 23 from cyc %0d", ev_cyc.size(), first_ev(), S, acc + 1);
    end
    exp_done++;
    checks++;
    if (FrameData !== exp_fd) begin errors++; $display("FAIL basic_data: %h, required %h", FrameData, exp_fd); end
    checks++;
    if (frames_done !== exp_done || error !== exp_err) begin
      errors++; $display("FAIL basic_status: done=%0d error=%b, required done=%0d error=%b", frames_done, error, exp_done, exp_err);
    end
  endtask

  task automatic test_bad_sync();
    int acc; bit ok;
    logic [31:0] w0, w1, w2, w3;
    clear_ev();
    send_word(32'hAB000000, 0, acc, ok);
    exp_err = 1'b1;
    wait_cycles(2);
    @(negedge CLK);
    checks++;
    if (ok !== 1'b1 || error !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || ev_cyc.size() != 0) begin
      errors++; $display("FAIL bad_sync: ok=%b error=%b busy=%b ready=%b strobes=%0d, required 1 1 0 1 0", ok, error, busy, in_ready, ev_cyc.size());
    end
    @(posedge CLK); #1;
    w0 = $urandom; w1 = $urandom; w2 = $urandom; w3 = $urandom;
    send_frame(32'hFA000500, w0, w1, w2, w3, 1'b0, 1, acc, ok);
    wait_cycles(S + 3);
    exp_fd = {w0, w1, w2, w3};
    checks++;
    if (ok !== 1'b1 || !strobe_matches(acc, 5, exp_done)) begin
      errors++; $display("FAIL bad_sync_recover: ok=%b %0d events from cyc %0d, required %0d on bit 5 from cyc %0d", ok, ev_cyc.size(), first_ev(), S, acc + 1);
    end
    exp_done++;
    checks++;
    if (FrameData !== exp_fd || frames_done !== exp_done) begin
      errors++; $display("FAIL bad_sync_data: %h done=%0d, required %h done=%0d", FrameData, frames_done, exp_fd, exp_done);
    end
  endtask

  task automatic test_out_of_range();
    int acc; bit ok;
    clear_ev();
    send_frame(32'hFA050000, $urandom, $urandom, $urandom, $urandom, 1'b0, 1, acc, ok);
    wait_cycles(S + 3);
    checks++;
    if (ok !== 1'b1 || ev_cyc.size() != 0) begin
      errors++; $display("FAIL range_skip: ok=%b strobes=%0d, required ok=1 strobes=0", ok, ev_cyc.size());
    end
    checks++;
    if (FrameData !== exp_fd || frames_done !== exp_done || error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL range_state: data=%h done=%0d error=%b busy=%b, required %h %0d 1 0", FrameData, frames_done, error, busy, exp_fd, exp_done);
    end
  endtask

  task automatic test_stall();
    int acc; bit ok, k, bad;
    logic [31:0] w0, w1, w2, w3, tr;
    clear_ev();
    w0 = $urandom; w1 = $urandom; w2 = $urandom; w3 = $urandom;
    send_word(32'hFA031300, 0, acc, ok);
    send_word(w0, 0, acc, k); ok = ok & k;
    send_word(w1, 0, acc, k); ok = ok & k;
    bad = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge CLK);
      if (busy !== 1'b1 || FrameStrobe !== '0) bad = 1'b1;
      @(posedge CLK); #1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL stall_hold: busy/strobe changed during stall, required busy=1 strobe=0"); end
    send_word(w2, 0, acc, k); ok = ok & k;
    send_word(w3, 0, acc, k); ok = ok & k;
`ifdef CONF_FRAME_CRC_EN
    tr = 32'hFA031300 ^ w0 ^ w1 ^ w2 ^ w3;
    send_word(tr, 0, acc, k); ok = ok & k;
`endif
    wait_cycles(S + 3);
    exp_fd = {w0, w1, w2, w3};
    checks++;
    if (ok !== 1'b1 || !strobe_matches(acc, 79, exp_done)) begin
      errors++; $display("FAIL stall_strobe: ok=%b %0d events from cyc %0d, required %0d on bit 79 from cyc %0d", ok, ev_cyc.size(), first_ev(), S, acc + 1);
    end
    exp_done++;
    checks++;
    if (FrameData !== exp_fd || frames_done !== exp_done) begin
      errors++; $display("FAIL stall_data: %h done=%0d, required %h done=%0d", FrameData, frames_done, exp_fd, exp_done);
    end
  endtask

  task automatic test_abort();
    int acc; bit ok, k, bad;
    logic [31:0] w0, w1, w2, w3;
    clear_ev();
    w0 = $urandom; w1 = $urandom;
    send_word(32'hFA020000, 0, acc, ok);
    send_word(w0, 0, acc, k); ok = ok & k;
    send_word(w1, 0, acc, k); ok = ok & k;
    MODE = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (ok !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_idle: ok=%b busy=%b ready=%b, required 1 0 0", ok, busy, in_ready);
    end
    in_valid = 1'b1; in_data = 32'hFA000000;
    bad = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge CLK);
      if (in_ready !== 1'b0) bad = 1'b1;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL mode_low_ready: in_ready rose with MODE=0, required 0"); end
    exp_fd = {w0, w1, exp_fd[63:0]};
    checks++;
    if (FrameData !== exp_fd || frames_done !== exp_done || error !== exp_err || ev_cyc.size() != 0) begin
      errors++; $display("FAIL abort_state: data=%h done=%0d error=%b strobes=%0d, required %h %0d %b 0", FrameData, frames_done, error, ev_cyc.size(), exp_fd, exp_done, exp_err);
    end
    MODE = 1'b1;
    wait_cycles(1);
    clear_ev();
    w0 = $urandom; w1 = $urandom; w2 = $urandom; w3 = $urandom;
    send_frame(32'hFA000000, w0, w1, w2, w3, 1'b0, 0, acc, ok);
    wait_cycles(S + 3);
    exp_fd = {w0, w1, w2, w3};
    checks++;
    if (ok !== 1'b1 || !strobe_matches(acc, 0, exp_done)) begin
      errors++; $display("FAIL abort_recover: ok=%b %0d events from cyc %0d, required %0d on bit 0 from cyc %0d", ok, ev_cyc.size(), first_ev(), S, acc + 1);
    end
    exp_done++;
    // MODE dropped in the first strobe cycle cuts the pulse to one cycle and skips the count
    clear_ev();
    send_frame(32'hFA020100, w3, w2, w1, w0, 1'b0, 0, acc, ok);
    MODE = 1'b0;
    wait_cycles(S + 3);
    exp_fd = {w3, w2, w1, w0};
    checks++;
    if (ev_cyc.size() != 1 || first_ev() != acc + 1 || frames_done !== exp_done) begin
      errors++; $display("FAIL strobe_truncate: %0d events from cyc %0d done=%0d, required 1 event at cyc %0d done=%0d", ev_cyc.size(), first_ev(), frames_done, acc + 1, exp_done);
    end
    MODE = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_random();
    logic [31:0] hdr, w0, w1, w2, w3;
    logic [7:0] s;
    int kind, idx, acc;
    bit ok, bad_crc;
    for (int n = 0; n < 40; n++) begin
      clear_ev();
      kind = $urandom_range(0, 9);
      hdr = $urandom; w0 = $urandom; w1 = $urandom; w2 = $urandom; w3 = $urandom;
      bad_crc = 1'b0;
      if (kind < 2) begin
        s = 8'($urandom_range(0, 254));
        if (s >= 8'hFA) s = s + 8'd1;
        hdr[31:24] = s;
      end else if (kind < 4) begin
        hdr[31:24] = 8'hFA;
        if ($urandom_range(0, 1) == 1) begin
          hdr[23:16] = 8'($urandom_range(4, 255)); hdr[15:8] = 8'($urandom_range(0, 19));
        end else begin
          hdr[23:16] = 8'($urandom_range(0, 3));   hdr[15:8] = 8'($urandom_range(20, 255));
        end
      end else begin
        hdr[31:24] = 8'hFA;
        hdr[23:16] = 8'($urandom_range(0, 3));
        hdr[15:8]  = 8'($urandom_range(0, 19));
      end
`ifdef CONF_FRAME_CRC_EN
      bad_crc = ($urandom_range(0, 4) == 0);
`endif
      idx = frame_target(hdr);
      if (idx == -2) send_word(hdr, 2, acc, ok);
      else send_frame(hdr, w0, w1, w2, w3, bad_crc, 2, acc, ok);
      wait_cycles(S + 3);
      if (idx < 0) begin
        exp_err = 1'b1; idx = -1;
      end else begin
        exp_fd = {w0, w1, w2, w3};
        if (bad_crc) begin exp_err = 1'b1; idx = -1; end
      end
      checks++;
      if (ok !== 1'b1 || !strobe_matches(acc, idx, exp_done)) begin
        errors++; $display("FAIL rand%0d_strobe: hdr=%h ok=%b %0d events from cyc %0d, required bit %0d from cyc %0d", n, hdr, ok, ev_cyc.size(), first_ev(), idx, acc + 1);
      end
      if (idx >= 0) exp_done++;
      checks++;
      if (FrameData !== exp_fd || frames_done !== exp_done || error !== exp_err) begin
        errors++; $display("FAIL rand%0d_state: data=%h done=%0d error=%b, required %h %0d %b", n, FrameData, frames_done, error, exp_fd, exp_done, exp_err);
      end
    end
  endtask

`ifdef CONF_FRAME_CRC_EN
  task automatic test_crc();
    int acc; bit ok;
    logic [31:0] w0, w1, w2, w3;
    w0 = $urandom; w1 = $urandom; w2 = $urandom; w3 = $urandom;
    clear_ev();
    send_frame(32'hFA010400, w0, w1, w2, w3, 1'b0, 0, acc, ok);
    wait_cycles(S + 3);
    exp_fd = {w0, w1, w2, w3};
    checks++;
    if (ok !== 1'b1 || !strobe_matches(acc, 24, exp_done)) begin
      errors++; $display("FAIL crc_good: %0d events from cyc %0d, required %0d on bit 24 from cyc %0d", ev_cyc.size(), first_ev(), S, acc + 1);
    end
    exp_done++;
    clear_ev();
    send_frame(32'hFA010400, w3, w2, w1, w0, 1'b1, 0, acc, ok);
    wait_cycles(S + 3);
    exp_fd = {w3, w2, w1, w0};
    exp_err = 1'b1;
    checks++;
    if (ok !== 1'b1 || ev_cyc.size() != 0 || error !== 1'b1 || frames_done !== exp_done) begin
      errors++; $display("FAIL crc_bad: strobes=%0d error=%b done=%0d, required 0 1 %0d", ev_cyc.size(), error, frames_done, exp_done);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int acc; bit ok, k;
    send_word(32'hFA030200, 0, acc, ok);
    send_word($urandom, 0, acc, k);
    resetn = 1'b0;
    #2;
    checks++;
    if (FrameData !== '0 || FrameStrobe !== '0 || {in_ready, busy, error} !== 3'b000 || frames_done !== 16'd0) begin
      errors++; $display("FAIL reset_mid: data=%h ready=%b busy=%b error=%b done=%0d, required all 0", FrameData, in_ready, busy, error, frames_done);
    end
    exp_fd = '0; exp_done = '0; exp_err = 1'b0;
    @(posedge CLK); #1;
    resetn = 1'b1;
    wait_cycles(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_sync();
    test_out_of_range();
    test_stall();
    test_abort();
`ifdef CONF_FRAME_CRC_EN
    test_crc();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
